// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, types and the key decode table for the
// keypad scanner and its debounce timer.
//   NUM_ROWS / NUM_COLS : matrix dimensions (4x4)
//   SETTLE_CYCLES       : clocks a freshly driven column needs before its rows are trusted
//   key_t               : 4-bit hex key code
//   key_code()          : row-major decode (row 3 carries '*'=E and '#'=F)
//   single_low()        : true when exactly one bit of an active-high vector is set
package keypad_pkg;

    localparam int NUM_ROWS      = 4;
    localparam int NUM_COLS      = 4;
    localparam int SETTLE_CYCLES = 3;

    typedef logic [3:0] key_t;

    function automatic key_t key_code(input logic [1:0] row, input logic [1:0] col);
        key_t code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Clearing the lowest set bit leaves zero only when a single bit was set.
    function automatic logic single_low(input logic [NUM_ROWS-1:0] low);
        return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
    endfunction

endpackage

// File: rtl/debounce_timer.sv
// debounce_timer: counts clocks while enable is high and emits a one-clock
// done pulse on the clock the count first reaches CYCLES-1. The count
// saturates there, so a held enable never re-fires; dropping enable clears it.
//   int_osc : clock (rising edge)
//   reset   : asynchronous, active-low
//   enable  : 1 = count, 0 = clear
//   done    : registered one-clock pulse
module debounce_timer #(
    parameter int CYCLES = 960000
) (
    input  logic int_osc,
    input  logic reset,
    input  logic enable,
    output logic done
);

    localparam int            CW   = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          done_q, done_d;

    // Next count and pulse: pulse only on the step that lands on LAST.
    always_comb begin
        dcnt_d = dcnt_q;
        done_d = 1'b0;
        if (!enable) begin
            dcnt_d = '0;
        end else if (dcnt_q != LAST) begin
            dcnt_d = dcnt_q + ONE;
            done_d = (dcnt_q == (LAST - ONE));
        end else begin
            dcnt_d = dcnt_q;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            dcnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            dcnt_q <= dcnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives one keypad column low at a time, detects a pressed
// key in the active column, times the debounce window for the control FSM
// and keeps a two-digit history of captured keys.
//   int_osc         : clock (rising edge)
//   reset           : asynchronous, active-low
//   rows            : keypad rows, active-low, asynchronous to int_osc
//   stop_counter    : 1 = freeze column rotation
//   debounce_enable : 1 = run debounce timer, 0 = clear it
//   write_enable    : 1 = capture the current key into the history
//   cols            : one-hot-low column drive
//   pushed          : key present in the active column (registered)
//   time_passed     : one-clock pulse when the debounce interval completes
//   digit_new/old   : most recent / previous captured key codes
// Build option: define MULTIKEY_REJECT_EN to ignore columns with more than
// one low row (ghost / multi-press rejection).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic                int_osc,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows,
    input  logic                stop_counter,
    input  logic                debounce_enable,
    input  logic                write_enable,
    output logic [NUM_COLS-1:0] cols,
    output logic                pushed,
    output logic                time_passed,
    output key_t                digit_new,
    output key_t                digit_old
);

    localparam int            DW          = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST    = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] SETTLE_LAST = DW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_ONE     = DW'(1);

    logic [NUM_ROWS-1:0] rows_meta_q, rows_s_q;
    logic [DW-1:0]       div_q, div_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] cols_q, cols_d;
    logic                settled_q, settled_d;
    logic                pushed_q, pushed_d;
    key_t                key_q, key_d;
    key_t                digit_new_q, digit_new_d;
    key_t                digit_old_q, digit_old_d;

    logic                advance_s;
    logic                row_hit_s;
    logic [NUM_ROWS-1:0] low_s;
    logic [1:0]          sel_row_s;

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            rows_meta_q <= 4'hF;
            rows_s_q    <= 4'hF;
        end else begin
            rows_meta_q <= rows;
            rows_s_q    <= rows_meta_q;
        end
    end

    // Scan divider, column rotation, key detection and digit history.
    always_comb begin
        low_s     = ~rows_s_q;
        advance_s = (div_q == DIV_LAST) && !stop_counter && !pushed_q;
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;

        // A new column needs a few clocks before its rows reflect it;
        // a frozen column keeps its settled flag across divider wraps.
        if (advance_s) begin
            col_idx_d = col_idx_q + 2'd1;
            cols_d    = ~(4'b0001 << col_idx_d);
            settled_d = 1'b0;
        end else begin
            col_idx_d = col_idx_q;
            cols_d    = cols_q;
            settled_d = settled_q | (div_q == SETTLE_LAST);
        end

        // Lowest-index low row wins the decode.
        if (low_s[0]) begin
            sel_row_s = 2'd0;
        end else if (low_s[1]) begin
            sel_row_s = 2'd1;
        end else if (low_s[2]) begin
            sel_row_s = 2'd2;
        end else begin
            sel_row_s = 2'd3;
        end

`ifdef MULTIKEY_REJECT_EN
        row_hit_s = settled_q && single_low(low_s);
`else
        row_hit_s = settled_q && (low_s != 4'h0);
`endif

        pushed_d = row_hit_s;
        key_d    = row_hit_s ? key_code(sel_row_s, col_idx_q) : key_q;

        // key_q is the code that goes with the current pushed flag.
        if (write_enable && pushed_q) begin
            digit_old_d = digit_new_q;
            digit_new_d = key_q;
        end else begin
            digit_old_d = digit_old_q;
            digit_new_d = digit_new_q;
        end
    end

    // State registers.
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            cols_q      <= 4'b1110;
            settled_q   <= 1'b0;
            pushed_q    <= 1'b0;
            key_q       <= 4'h0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
        end else begin
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            cols_q      <= cols_d;
            settled_q   <= settled_d;
            pushed_q    <= pushed_d;
            key_q       <= key_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
        end
    end

    debounce_timer #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .int_osc (int_osc),
        .reset   (reset),
        .enable  (debounce_enable),
        .done    (time_passed)
    );

    assign cols      = cols_q;
    assign pushed    = pushed_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;

endmodule
